// File: rtl/sdram_write_ppfifo_pkg.sv
// Shared definitions for the SDRAM write ping-pong FIFO: bank states,
// size port width and the mask/data field layout of a stored word.
package sdram_ppfifo_defines;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  localparam int SIZE_WIDTH = 24;

  // Word layout: {mask[3:0], data[31:0]}; mask[3:2] covers the top half.
  localparam int DATA_LSB      = 0;
  localparam int DATA_MSB      = 31;
  localparam int MASK_LSB      = 32;
  localparam int MASK_MSB      = 35;
  localparam int MASK_TOP_LSB  = 34;
  localparam int MASK_BOT_MSB  = 33;

endpackage

// File: rtl/sdram_write_ppfifo_ram.sv
// Simple dual-port RAM holding both banks, addressed {bank, index},
// with one write port and a registered read port.
module sdram_ppfifo_ram #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset so rd_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_write_ppfifo.sv
// Two-bank ping-pong buffer: the bus writer fills one bank while the SDRAM
// write engine drains the other through a first-word-fall-through port.
module sdram_write_ppfifo
  import sdram_ppfifo_defines::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [1:0]            wr_ready,
  input  logic [1:0]            wr_activate,
  output logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_strobe,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_overflow,
  output logic                  rd_ready,
  input  logic                  rd_activate,
  output logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_strobe,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  inactive
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic [CW-1:0] count_q [2];
  logic [CW-1:0] count_d [2];
  logic          head_q, head_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_cur;
  logic [CW-1:0] rd_size_q, rd_size_d;
  logic [1:0]    wr_act_q, wr_ready_q;
  logic          rd_act_q, rd_ready_q, overflow_q, inactive_q;
  logic          overflow_d, rd_live, full_d, reading_d, busy_d;

  logic [1:0]    act_eff, wr_rise, wr_fall, commit;
  logic          wr_bank, rd_rise, rd_fall, reading_q, rd_start;

  logic                  ram_we;
  logic [ADDR_WIDTH:0]   ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // With both activate bits set only bank 0 is honoured.
  assign act_eff   = (&wr_activate) ? 2'b01 : wr_activate;
  assign wr_rise   = act_eff & ~wr_act_q;
  assign wr_fall   = ~act_eff & wr_act_q;
  assign wr_bank   = act_eff[1];
  assign rd_rise   = rd_activate & ~rd_act_q;
  assign rd_fall   = ~rd_activate & rd_act_q;
  assign reading_q = (state_q[0] == BANK_READING) || (state_q[1] == BANK_READING);
  assign rd_start  = rd_rise && !reading_q && (state_q[head_q] == BANK_FULL);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    rd_ptr_cur = rd_ptr_q;
    rd_size_d  = rd_size_q;
    commit     = '0;
    overflow_d = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_raddr  = '0;
    rd_live    = 1'b0;
    full_d     = 1'b0;
    reading_d  = 1'b0;
    busy_d     = 1'b0;

    for (int i = 0; i < 2; i++) begin
      if (wr_rise[i] && state_q[i] == BANK_EMPTY) begin
        state_d[i] = BANK_WRITING;
        count_d[i] = '0;
      end else if (wr_fall[i] && state_q[i] == BANK_WRITING) begin
        commit[i]  = (count_q[i] != '0);
        state_d[i] = commit[i] ? BANK_FULL : BANK_EMPTY;
      end
    end

    if (wr_strobe) begin
      if (act_eff != 2'b00 && state_d[wr_bank] == BANK_WRITING && count_d[wr_bank] < DEPTH_C) begin
        ram_we           = 1'b1;
        ram_waddr        = {wr_bank, count_d[wr_bank][ADDR_WIDTH-1:0]};
        count_d[wr_bank] = count_d[wr_bank] + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Starting a read hands the head to the other bank, the next in line.
    if (rd_start) begin
      state_d[head_q] = BANK_READING;
      rd_bank_d       = head_q;
      rd_ptr_cur      = '0;
      rd_ptr_d        = '0;
      head_d          = ~head_q;
    end else if (rd_fall && state_q[rd_bank_q] == BANK_READING) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      count_d[rd_bank_q] = '0;
    end

    rd_live = rd_activate && (rd_start || state_q[rd_bank_q] == BANK_READING);
    if (rd_strobe && rd_live && rd_ptr_cur < rd_size_q) begin
      rd_ptr_d = rd_ptr_cur + 1'b1;
    end

    if (commit == 2'b11) begin
      head_d = 1'b0;
    end else if (commit[0] && state_q[1] != BANK_FULL) begin
      head_d = 1'b0;
    end else if (commit[1] && state_q[0] != BANK_FULL) begin
      head_d = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      full_d    = full_d | (state_d[i] == BANK_FULL);
      reading_d = reading_d | (state_d[i] == BANK_READING);
      busy_d    = busy_d | (state_d[i] == BANK_WRITING && count_d[i] != '0);
    end

    // When idle the RAM keeps presenting word 0 of the head bank.
    if (reading_d) begin
      ram_raddr = {rd_bank_d, rd_ptr_d[ADDR_WIDTH-1:0]};
    end else begin
      ram_raddr = {head_d, {ADDR_WIDTH{1'b0}}};
      rd_size_d = (state_d[head_d] == BANK_FULL) ? count_d[head_d] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= BANK_EMPTY;
        count_q[i] <= '0;
      end
      head_q     <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_size_q  <= '0;
      wr_act_q   <= '0;
      rd_act_q   <= 1'b0;
      wr_ready_q <= '0;
      rd_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      inactive_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= state_d[i];
        count_q[i]    <= count_d[i];
        wr_ready_q[i] <= (state_d[i] == BANK_EMPTY);
      end
      head_q     <= head_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_size_q  <= rd_size_d;
      wr_act_q   <= act_eff;
      rd_act_q   <= rd_activate;
      rd_ready_q <= full_d && !reading_d;
      overflow_q <= overflow_d;
      inactive_q <= !full_d && !reading_d && !busy_d;
    end
  end

  sdram_ppfifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wr_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign wr_ready    = wr_ready_q;
  assign wr_size     = SIZE_WIDTH'(DEPTH);
  assign wr_overflow = overflow_q;
  assign rd_ready    = rd_ready_q;
  assign rd_size     = SIZE_WIDTH'(rd_size_q);
  assign rd_data     = ram_rdata;
  assign inactive    = inactive_q;

endmodule

// File: tb/tb_sdram_write_ppfifo.sv
// Scoreboard bench for the ping-pong FIFO: a queue model of committed banks
// feeds expected read words to a monitor that checks every consumed word.
module tb_sdram_write_ppfifo;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_ready;
  logic [1:0]  wr_activate;
  logic [23:0] wr_size;
  logic        wr_strobe;
  logic [35:0] wr_data;
  logic        wr_overflow;
  logic        rd_ready;
  logic        rd_activate;
  logic [23:0] rd_size;
  logic        rd_strobe;
  logic [35:0] rd_data;
  logic        inactive;

  int checks   = 0;
  int failures = 0;
  int ovfSeen  = 0;
  int ovfExp   = 0;
  bit monEn    = 1'b0;

  int          commitSize  [$];
  logic [35:0] commitWords [$];
  logic [35:0] expQ        [$];

  sdram_write_ppfifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ready    (wr_ready),
    .wr_activate (wr_activate),
    .wr_size     (wr_size),
    .wr_strobe   (wr_strobe),
    .wr_data     (wr_data),
    .wr_overflow (wr_overflow),
    .rd_ready    (rd_ready),
    .rd_activate (rd_activate),
    .rd_size     (rd_size),
    .rd_strobe   (rd_strobe),
    .rd_data     (rd_data),
    .inactive    (inactive)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: every consumed read word is popped from the scoreboard.
  always @(negedge clk) begin
    if (monEn && rd_activate && rd_strobe) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rd_unexpected_word actual=%h expected=none", rd_data);
      end else begin
        checkOutput("rd_data", 64'(rd_data), 64'(expQ.pop_front()));
      end
    end
    if (monEn && wr_overflow) ovfSeen++;
  end

  task automatic pushWords(input int n, input logic [35:0] base, output int stored);
    logic [35:0] w;
    stored = 0;
    for (int i = 0; i < n; i++) begin
      w = (base != 0) ? base + 36'(i) : {4'($urandom), 32'($urandom)};
      wr_data   = w;
      wr_strobe = 1'b1;
      if (stored < DEPTH) begin
        commitWords.push_back(w);
        stored++;
      end else begin
        ovfExp++;
      end
      tick();
      if ($urandom_range(3) == 0) begin
        wr_strobe = 1'b0;
        tick();
      end
    end
    wr_strobe = 1'b0;
  endtask

  task automatic applyStimulus(input int bank, input int n, input logic [35:0] base);
    int stored;
    wr_activate = (bank == 0) ? 2'b01 : 2'b10;
    tick();
    pushWords(n, base, stored);
    wr_activate = 2'b00;
    tick();
    if (stored > 0) commitSize.push_back(stored);
  endtask

  task automatic startRead(input int k);
    int waited;
    int s;
    logic [35:0] w;
    waited = 0;
    while (!rd_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!rd_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL rd_ready_wait actual=0 expected=1");
      return;
    end
    if (commitSize.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL rd_ready_spurious actual=1 expected=0");
      return;
    end
    s = commitSize.pop_front();
    checkOutput("rd_size", 64'(rd_size), 64'(s));
    checkOutput("rd_word0", 64'(rd_data), 64'(commitWords[0]));
    if (k < 0 || k > s) k = s;
    for (int i = 0; i < s; i++) begin
      w = commitWords.pop_front();
      if (i < k) expQ.push_back(w);
    end
    rd_activate = 1'b1;
    tick();
    for (int i = 0; i < k; i++) begin
      rd_strobe = 1'b1;
      tick();
      if ($urandom_range(3) == 0) begin
        rd_strobe = 1'b0;
        tick();
      end
    end
    rd_strobe = 1'b0;
  endtask

  task automatic readBank(input int k);
    startRead(k);
    rd_activate = 1'b0;
    tick();
  endtask

  initial begin
    int o;
    int stored;
    int nb;
    int b;
    int n;
    rst_n       = 1'b0;
    wr_activate = 2'b00;
    wr_strobe   = 1'b0;
    wr_data     = '0;
    rd_activate = 1'b0;
    rd_strobe   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wr_ready", 64'(wr_ready), 64'd0);
    checkOutput("reset_inactive", 64'(inactive), 64'd1);
    checkOutput("reset_rd_ready", 64'(rd_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("wr_ready_after_reset", 64'(wr_ready), 64'd3);
    checkOutput("wr_size", 64'(wr_size), 64'd256);
    monEn = 1'b1;

    // Four directed words into bank 0.
    applyStimulus(0, 4, 36'h3_0000_0001);
    checkOutput("rd_ready_after_commit", 64'(rd_ready), 64'd1);
    checkOutput("inactive_with_full", 64'(inactive), 64'd0);
    checkOutput("rd_size_directed", 64'(rd_size), 64'd4);
    checkOutput("rd_data_directed", 64'(rd_data), 64'h3_0000_0001);
    readBank(-1);
    checkOutput("wr_ready0_after_read", 64'(wr_ready[0]), 64'd1);
    checkOutput("inactive_after_read", 64'(inactive), 64'd1);

    // Reset in the middle of traffic.
    applyStimulus(0, 3, 36'h0);
    wr_activate = 2'b10;
    tick();
    pushWords(2, 36'h0, stored);
    checkOutput("rd_ready_before_reset", 64'(rd_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wr_ready", 64'(wr_ready), 64'd0);
    checkOutput("midreset_rd_ready", 64'(rd_ready), 64'd0);
    checkOutput("midreset_rd_size", 64'(rd_size), 64'd0);
    checkOutput("midreset_rd_data", 64'(rd_data), 64'd0);
    checkOutput("midreset_overflow", 64'(wr_overflow), 64'd0);
    checkOutput("midreset_inactive", 64'(inactive), 64'd1);
    commitSize.delete();
    commitWords.delete();
    expQ.delete();
    wr_activate = 2'b00;
    tick();
    rst_n = 1'b1;
    checkOutput("wr_ready_before_first_clock", 64'(wr_ready), 64'd0);
    tick();
    checkOutput("wr_ready_first_clock", 64'(wr_ready), 64'd3);

    // Full bank then a short bank: commit order must be kept.
    applyStimulus(0, 256, 36'h0);
    applyStimulus(1, 3, 36'h0);
    readBank(-1);
    readBank(-1);

    // One strobe beyond capacity.
    o = ovfSeen;
    applyStimulus(0, 257, 36'h0);
    tick();
    checkOutput("overflow_pulses", 64'(ovfSeen - o), 64'd1);
    readBank(-1);

    // Empty activation leaves nothing committed.
    wr_activate = 2'b10;
    tick();
    wr_activate = 2'b00;
    tick();
    tick();
    checkOutput("empty_release_rd_ready", 64'(rd_ready), 64'd0);
    checkOutput("empty_release_inactive", 64'(inactive), 64'd1);
    checkOutput("empty_release_wr_ready", 64'(wr_ready), 64'd3);

    // Reader releases bank 0 in the same cycle the writer commits bank 1.
    applyStimulus(0, 5, 36'h0);
    startRead(-1);
    wr_activate = 2'b10;
    tick();
    pushWords(3, 36'h0, stored);
    rd_activate = 1'b0;
    wr_activate = 2'b00;
    tick();
    if (stored > 0) commitSize.push_back(stored);
    checkOutput("swap_wr_ready0", 64'(wr_ready[0]), 64'd1);
    tick();
    checkOutput("swap_rd_ready", 64'(rd_ready), 64'd1);
    readBank(-1);

    // Randomised bursts, sometimes both banks, sometimes partial reads.
    for (int it = 0; it < 20; it++) begin
      nb = $urandom_range(1, 2);
      b  = $urandom_range(0, 1);
      for (int j = 0; j < nb; j++) begin
        n = ($urandom_range(9) == 0) ? 250 + $urandom_range(10) : $urandom_range(0, 40);
        applyStimulus(b ^ j, n, 36'h0);
      end
      while (commitSize.size() > 0) begin
        readBank(($urandom_range(3) == 0) ? $urandom_range(0, 10) : -1);
      end
      tick();
      checkOutput("random_idle_inactive", 64'(inactive), 64'd1);
    end

    tick();
    checkOutput("overflow_total", 64'(ovfSeen), 64'(ovfExp));
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
